// File: rtl/imem_loader.sv
// UART frame loader for the instruction memory.
// Receives SYNC, length N, 4*N little-endian data bytes and an XOR checksum.
// Each completed word is written to imem, and the core is held in reset while
// a frame is in flight.
module imem_loader #(
    parameter int         MEM_WORDS = 14,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] core_pc,
    output logic        imem_we,
    output logic [31:0] imem_a,
    output logic [31:0] imem_wd,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_t;

    localparam logic [7:0] MAX_N = 8'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  widx_q, widx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        crst_n_q, crst_n_d;

    // Next-state and registered-output logic; only strobed bytes advance the frame.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        csum_d   = csum_q;
        asm_d    = asm_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        crst_n_d = crst_n_q;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d  = LEN;
                        crst_n_d = 1'b0;
                        err_d    = 1'b0;
                        widx_d   = '0;
                        bcnt_d   = '0;
                        csum_d   = '0;
                        addr_d   = '0;
                    end
                end
                LEN: begin
                    if (rx_data != 8'd0 && rx_data <= MAX_N) begin
                        state_d = DATA;
                        len_d   = rx_data;
                    end else begin
                        // Bad length: abort, keep the core held until a good frame lands.
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        wd_d   = {rx_data, asm_q};
                        addr_d = {22'd0, widx_q, 2'b00};
                        widx_d = widx_q + 8'd1;
                        if (widx_q == len_q - 8'd1) state_d = CSUM;
                    end else begin
                        asm_d[8*bcnt_q +: 8] = rx_data;
                    end
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data == csum_q) begin
                        done_d   = 1'b1;
                        crst_n_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset aborts any frame in flight and releases the core.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            csum_q   <= '0;
            asm_q    <= '0;
            addr_q   <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            crst_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            csum_q   <= csum_d;
            asm_q    <= asm_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            crst_n_q <= crst_n_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign imem_we    = we_q;
    assign imem_wd    = wd_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst_n = crst_n_q;
    // The last write of a frame lands after the FSM is already heading back,
    // so the pending write also claims the address port.
    assign imem_a     = (busy || we_q) ? addr_q : core_pc;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level model plus directed frames.
module tb_imem_loader;

    localparam int         MEMW = 14;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] core_pc = 32'h0000_1000;
    logic        imem_we, core_rst_n, busy, done, err;
    logic [31:0] imem_a, imem_wd;

    imem_loader #(.MEM_WORDS(MEMW), .SYNC_BYTE(SYNC)) dut (
        .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_data(rx_data),
        .core_pc(core_pc), .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Core PC keeps moving so address muxing is visible.
    always @(posedge CLK) begin
        #2;
        core_pc = core_pc + 32'h4;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [7:0]  fq[$];
    bit          in_frame;
    logic        exp_busy, exp_we, exp_done, exp_err, exp_crst;
    logic [31:0] exp_wa, exp_wd;

    task automatic model_byte(input logic [7:0] b);
        int n, sz, k;
        logic [7:0] x;
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1;
                fq.delete();
                exp_crst = 0;
                exp_err  = 0;
                exp_busy = 1;
            end
        end else begin
            fq.push_back(b);
            n  = int'(fq[0]);
            sz = fq.size();
            if (sz == 1) begin
                if (n == 0 || n > MEMW) begin
                    in_frame = 0;
                    exp_busy = 0;
                    exp_err  = 1;
                end
            end else if (sz <= 1 + 4 * n) begin
                if ((sz - 1) % 4 == 0) begin
                    k = (sz - 1) / 4 - 1;
                    exp_we = 1;
                    exp_wa = 32'(k * 4);
                    exp_wd = {fq[4*k+4], fq[4*k+3], fq[4*k+2], fq[4*k+1]};
                end
            end else begin
                x = 8'h00;
                for (int i = 1; i <= 4 * n; i++) x ^= fq[i];
                in_frame = 0;
                exp_busy = 0;
                if (b == x) begin
                    exp_done = 1;
                    exp_crst = 1;
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    // Model advances on the same edges as the DUT; expectations describe the following cycle.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_frame = 0;
            fq.delete();
            exp_busy = 0; exp_we = 0; exp_done = 0; exp_err = 0; exp_crst = 1;
            exp_wa = 0; exp_wd = 0;
        end else begin
            exp_we   = 0;
            exp_done = 0;
            if (rx_valid) model_byte(rx_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [63:0] wlog[$];
    int          ndone = 0;

    always @(negedge CLK) begin
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, exp_crst});
        if (exp_we) begin
            chk("imem_a_wr", imem_a, exp_wa);
            chk("imem_wd_wr", imem_wd, exp_wd);
        end else if (!exp_busy) begin
            chk("imem_a_pc", imem_a, core_pc);
        end
        if (!RST_N) chk("imem_wd_rst", imem_wd, 32'h0);
        if (imem_we) wlog.push_back({imem_a, imem_wd});
        if (done) ndone++;
    end

    // ---------------- stimulus ----------------
    logic [7:0] frm[$];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            @(posedge CLK);
            #2;
            rx_valid = 1'b0;
            idle(gap);
        end
    endtask

    task automatic clear_log();
        wlog.delete();
        ndone = 0;
    endtask

    logic [7:0] xs;
    logic [7:0] bt;

    initial begin
        idle(3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_crst", {31'd0, core_rst_n}, 32'd1);
        RST_N = 1'b1;
        idle(2);

        // Stray bytes while idle
        frm = '{8'h00, 8'hFF};
        send_frame(1);
        chk("stray_busy", {31'd0, busy}, 32'd0);

        // Single-word frame
        clear_log();
        frm = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(1);
        idle(2);
        chk("a_nwr", wlog.size(), 32'd1);
        chk("a_addr", wlog[0][63:32], 32'h0);
        chk("a_data", wlog[0][31:0], 32'h0000_0013);
        chk("a_done", ndone, 32'd1);

        // Two-word frame, checksum 0x37
        clear_log();
        frm = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80, 8'h37};
        send_frame(2);
        idle(2);
        chk("b_nwr", wlog.size(), 32'd2);
        chk("b_a0", wlog[0][63:32], 32'h0);
        chk("b_d0", wlog[0][31:0], 32'h0010_0093);
        chk("b_a1", wlog[1][63:32], 32'h4);
        chk("b_d1", wlog[1][31:0], 32'h8000_0337);
        chk("b_done", ndone, 32'd1);
        chk("b_err", {31'd0, err}, 32'd0);

        // Length out of range
        clear_log();
        frm = '{8'hA5, 8'h0F};
        send_frame(1);
        idle(2);
        chk("len_nwr", wlog.size(), 32'd0);
        chk("len_err", {31'd0, err}, 32'd1);
        chk("len_crst", {31'd0, core_rst_n}, 32'd0);
        chk("len_busy", {31'd0, busy}, 32'd0);

        // Zero length
        frm = '{8'hA5, 8'h00};
        send_frame(0);
        idle(2);
        chk("len0_err", {31'd0, err}, 32'd1);

        // Bad checksum, then a good frame recovers
        clear_log();
        frm = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80, 8'h00};
        send_frame(1);
        idle(2);
        chk("cs_nwr", wlog.size(), 32'd2);
        chk("cs_err", {31'd0, err}, 32'd1);
        chk("cs_done", ndone, 32'd0);
        chk("cs_crst", {31'd0, core_rst_n}, 32'd0);
        frm = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(0);
        idle(2);
        chk("rec_err", {31'd0, err}, 32'd0);
        chk("rec_crst", {31'd0, core_rst_n}, 32'd1);

        // Sync byte inside data is plain data
        clear_log();
        frm = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        send_frame(0);
        idle(2);
        chk("sd_data", wlog[0][31:0], 32'hA5A5_A5A5);
        chk("sd_done", ndone, 32'd1);

        // Full-size frame, back-to-back bytes (checksum lands with the last write)
        clear_log();
        frm = '{};
        frm.push_back(8'hA5);
        frm.push_back(8'(MEMW));
        xs = 8'h00;
        for (int w = 0; w < MEMW; w++) begin
            for (int k = 0; k < 4; k++) begin
                bt = 8'(w * 16 + k + 1);
                frm.push_back(bt);
                xs ^= bt;
            end
        end
        frm.push_back(xs);
        send_frame(0);
        idle(2);
        chk("full_nwr", wlog.size(), 32'd14);
        chk("full_last_a", wlog[13][63:32], 32'h34);
        chk("full_last_d", wlog[13][31:0], 32'hD4D3_D2D1);
        chk("full_done", ndone, 32'd1);

        // Reset in the middle of a frame
        clear_log();
        frm = '{8'hA5, 8'h01, 8'h11, 8'h22};
        send_frame(1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_crst", {31'd0, core_rst_n}, 32'd1);
        chk("mr_we", {31'd0, imem_we}, 32'd0);
        chk("mr_a", imem_a, core_pc);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        idle(1);
        frm = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(1);
        idle(2);
        chk("mr_nwr", wlog.size(), 32'd1);
        chk("mr_done", ndone, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_WORDS, default 14, number of writable instruction words.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 core_pc  input  32  program counter from the core.
REQ-008 imem_we  output  1  instruction-memory write enable.
REQ-009 imem_a  output  32  instruction-memory address (core_pc or loader address).
REQ-010 imem_wd  output  32  instruction-memory write data.
REQ-011 core_rst_n  output  1  active-low hold of the core; low while loading.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when a frame commits successfully.
REQ-014 err  output  1  sticky frame-error flag.

Function
REQ-015 Frame: SYNC_BYTE, length byte N (words), 4*N data bytes little-endian per word, checksum byte equal to the XOR of all 4*N data bytes.
REQ-016 States: IDLE, LEN, DATA, CSUM; only bytes with rx_valid=1 advance the FSM.
REQ-017 IDLE: byte == SYNC_BYTE -> LEN, core_rst_n=0 from the next cycle, err cleared, word index, byte count and checksum cleared; any other byte is ignored.
REQ-018 LEN: 1 <= N <= MEM_WORDS -> DATA with N latched; N==0 or N>MEM_WORDS -> IDLE, err=1, core_rst_n stays 0.
REQ-019 DATA: byte k of the current word (k=0..3) goes to bits [8k+7:8k] of the word assembly register; every data byte is XORed into the running checksum.
REQ-020 On the 4th byte of a word: imem_wd = assembled word, imem_a = {word_index, 2'b00}, imem_we=1 for exactly the next cycle; the word index then increments.
REQ-021 After the 4th byte of word N-1 the FSM moves to CSUM; a byte arriving in the same cycle as imem_we is processed normally.
REQ-022 CSUM: byte == running checksum -> IDLE, done pulses 1 cycle and core_rst_n returns high in the same cycle; mismatch -> IDLE, err=1, core_rst_n stays 0.
REQ-023 imem_a = core_pc when busy=0 and no write is pending; while busy=1 or imem_we=1, imem_a = loader address.
REQ-024 imem_we is never asserted outside DATA-triggered write cycles; word index never reaches MEM_WORDS while imem_we=1.
REQ-025 SYNC_BYTE received in LEN, DATA or CSUM is treated as data, not as a restart.
REQ-026 With core_rst_n=0 after an error, only a new valid frame releases the core.

Reset
REQ-027 While RST_N=0: state IDLE, imem_we=0, imem_wd=0, done=0, err=0, busy=0, core_rst_n=1, counters and checksum 0, imem_a follows core_pc.
REQ-028 RST_N assertion mid-frame aborts the frame immediately; the partially written memory is left as is; core_rst_n=1 after reset.

Verification
REQ-029 Frame A5,01,13,00,00,00,13 -> one imem_we pulse, imem_a=0, imem_wd=32'h00000013; done pulse; core_rst_n low from the cycle after A5 until the done cycle.
REQ-030 Frame A5,02, words 32'h00100093 and 32'h80000337, correct XOR -> writes at addresses 0x0 and 0x4 in order, done=1, err=0.
REQ-031 Length byte 0x0F with MEM_WORDS=14 -> no imem_we, err=1, FSM back to IDLE, core_rst_n stays 0.
REQ-032 Valid length and data but wrong checksum byte -> all N writes occur, err=1, no done, core_rst_n stays 0; a following good frame clears err and releases the core.
REQ-033 Stray bytes 0x00, 0xFF in IDLE -> no state change; imem_a tracks core_pc each cycle.
REQ-034 RST_N pulsed low after the 2nd data byte -> outputs at reset values, no imem_we; a subsequent full frame completes normally.
